dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_rr2.sv | 19 +
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, the zero word and the default burst limit.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int          BURST_MAX_DEF = 4;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  // One-hot grant vector {gnt1, gnt0} for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not the last owner. Purely combinational.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_owner ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU port 0, loader/debug port 1) with a
// bounded burst per owner, combinational grant and one-cycle read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 16,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic          mem_dwce,
  output logic          mem_drce,
  output logic [AW-1:0] mem_daddr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int            CW      = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid0_q, rvalid1_q;

  logic [1:0]    rr_gnt;
  logic [1:0]    gnt_vec;
  logic          own, own_req, oth_req, cnt_full;

  arb_rr2 u_rr (
    .req        ({req1, req0}),
    .last_owner (last_q),
    .gnt        (rr_gnt)
  );

  assign own      = (state_q == ST_OWN1);
  assign own_req  = own ? req1 : req0;
  assign oth_req  = own ? req0 : req1;
  assign cnt_full = (cnt_q == CNT_MAX);

  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_vec = 2'b00;

    if (rst_n) begin
      case (state_q)
        ST_IDLE: gnt_vec = rr_gnt;
        ST_OWN0, ST_OWN1: begin
          // Hand over when the owner has used its burst or gone quiet.
          if (oth_req && (!own_req || cnt_full))
            gnt_vec = port_onehot(~own);
          else if (own_req)
            gnt_vec = port_onehot(own);
        end
        default: gnt_vec = 2'b00;
      endcase

      if (gnt_vec == 2'b00) begin
        state_d = ST_IDLE;
      end else begin
        state_d = gnt_vec[1] ? ST_OWN1 : ST_OWN0;
        last_d  = gnt_vec[1];
        if (state_q == state_d)
          cnt_d = cnt_full ? cnt_q : cnt_q + CNT_ONE;
        else
          cnt_d = CNT_ONE;
      end
    end
  end

  assign gnt0 = gnt_vec[0];
  assign gnt1 = gnt_vec[1];

  always_comb begin
    mem_dwce  = 1'b0;
    mem_drce  = 1'b0;
    mem_daddr = '0;
    mem_wdata = ZERO_WORD;
    if (gnt_vec[0]) begin
      mem_dwce  = we0;
      mem_drce  = ~we0;
      mem_daddr = addr0;
      mem_wdata = wdata0;
    end else if (gnt_vec[1]) begin
      mem_dwce  = we1;
      mem_drce  = ~we1;
      mem_daddr = addr1;
      mem_wdata = wdata1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= gnt_vec[0] & ~we0;
      rvalid1_q <= gnt_vec[1] & ~we1;
    end
  end

  // The memory returns zero when not read, but gate anyway so the idle port stays clean.
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rvalid0_q ? mem_rdata : ZERO_WORD;
  assign rdata1  = rvalid1_q ? mem_rdata : ZERO_WORD;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle memory.
// Expected values are hand-derived constants and a fixed grant pattern.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_dwce, mem_drce;
  logic [15:0] mem_daddr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:65535];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(16), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_dwce  (mem_dwce),
    .mem_drce  (mem_drce),
    .mem_daddr (mem_daddr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: registered read data, zero when not read.
  always @(posedge clk) begin
    mem_rdata <= mem_drce ? mem[mem_daddr] : 32'h0;
    if (mem_dwce) mem[mem_daddr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_g1 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                        1'b0, 1'b0, 1'b0, 1'b0};
  logic prev_g0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hA000_0000 | i;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0010; addr1 = 16'h0020;
    wdata0 = 32'h0; wdata1 = 32'h0;

    // Outputs held quiet while in reset.
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_drce", mem_drce, 0);
    check("rst_dwce", mem_dwce, 0);
    step(); step();
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    rst_n = 1'b1;

    // First tie after reset goes to port 0.
    @(negedge clk);
    check("tie_gnt0", gnt0, 1);
    check("tie_gnt1", gnt1, 0);
    check("tie_daddr", mem_daddr, 32'h10);
    check("tie_drce", mem_drce, 1);
    step(); req0 = 1'b0;
    @(negedge clk);
    check("sw_gnt1", gnt1, 1);
    check("sw_daddr", mem_daddr, 32'h20);
    check("rd0_valid", rvalid0, 1);
    check("rd0_data", rdata0, 32'hA000_0010);
    check("rd0_other", rdata1, 0);
    step(); req1 = 1'b0;
    @(negedge clk);
    check("idle_gnt", {gnt1, gnt0}, 0);
    check("idle_drce", mem_drce, 0);
    check("idle_dwce", mem_dwce, 0);
    check("idle_daddr", mem_daddr, 0);
    check("idle_wdata", mem_wdata, 0);
    check("rd1_valid", rvalid1, 1);
    check("rd1_data", rdata1, 32'hA000_0020);
    check("rd1_other", rdata0, 0);
    step();
    @(negedge clk);
    check("idle2_rvalid1", rvalid1, 0);
    check("idle2_rdata0", rdata0, 0);
    check("idle2_rdata1", rdata1, 0);

    // Full-width address passes through untouched.
    step(); req0 = 1'b1; addr0 = 16'hFFF0;
    @(negedge clk);
    check("wide_gnt0", gnt0, 1);
    check("wide_daddr", mem_daddr, 32'hFFF0);
    step(); req0 = 1'b0;
    @(negedge clk);
    check("wide_rdata0", rdata0, 32'hA000_FFF0);

    // Port 1 writes, port 0 reads the same word the next cycle.
    step(); req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0005; wdata1 = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_gnt1", gnt1, 1);
    check("wr_dwce", mem_dwce, 1);
    check("wr_drce", mem_drce, 0);
    check("wr_daddr", mem_daddr, 32'h5);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 16'h0005;
    @(negedge clk);
    check("raw_gnt0", gnt0, 1);
    check("raw_drce", mem_drce, 1);
    step(); req0 = 1'b0;
    @(negedge clk);
    check("raw_rvalid0", rvalid0, 1);
    check("raw_rdata0", rdata0, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    check("raw_rvalid0_once", rvalid0, 0);

    // Burst pattern with both ports requesting from a fresh reset.
    step(); rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0030; addr1 = 16'h0040;
    step(); rst_n = 1'b1;
    prev_g0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("burst_gnt1_%0d", i), gnt1, exp_g1[i]);
      check($sformatf("burst_gnt0_%0d", i), gnt0, !exp_g1[i]);
      check($sformatf("burst_rvalid0_%0d", i), rvalid0, prev_g0);
      prev_g0 = !exp_g1[i];
      step();
    end

    // Port 1 alone for 10 cycles; its counter must saturate.
    req0 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("solo_gnt1_%0d", j), gnt1, 1);
      check($sformatf("solo_gnt0_%0d", j), gnt0, 0);
      step();
    end
    req0 = 1'b1;
    @(negedge clk);
    check("sat_switch_gnt0", gnt0, 1);
    check("sat_switch_gnt1", gnt1, 0);

    // Reset right after a granted read drops the pending return.
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rstrd_rvalid0", rvalid0, 0);
    check("rstrd_gnt", {gnt1, gnt0}, 0);
    check("rstrd_en", {mem_dwce, mem_drce}, 0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("rstrd_idle_gnt0", gnt0, 1);
    step(); req0 = 1'b0; req1 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
